chord_voicer: RTL and testbench

//  Parametrised successor to the fixed major-triad mixer. Up to 4 sawtooth voices are derived

---
 rtl/chord_voicer_pkg.sv | 49 ++++
 rtl/chord_voicer_if.sv | 25 ++
 rtl/chord_env_gain.sv | 38 +++
 rtl/chord_voicer.sv | 160 ++++++++++++++++
 tb/tb_chord_voicer.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/chord_voicer_pkg.sv
// Shared definitions for the chord voicer: chord shapes, FSM encoding and the
// shift-add interval table that turns a root increment into per-voice increments.
package chord_voicer_pkg;

  localparam logic [1:0] MODE_MAJOR = 2'd0;
  localparam logic [1:0] MODE_MINOR = 2'd1;
  localparam logic [1:0] MODE_DOM7  = 2'd2;
  localparam logic [1:0] MODE_POWER = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VOICE = 2'd1,
    ST_SCALE = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Ratios are approximated with shifts only; the two spare bits hold up to 3*f.
  function automatic logic [33:0] voice_inc(input logic [31:0] f,
                                            input logic [1:0]  mode,
                                            input logic [1:0]  k);
    logic [33:0] fw;
    fw        = {2'b00, f};
    voice_inc = fw;
    case (k)
      2'd1: begin
        case (mode)
          MODE_MINOR: voice_inc = fw + (fw >> 3) + (fw >> 4);
          MODE_POWER: voice_inc = fw + (fw >> 1);
          default:    voice_inc = fw + (fw >> 2);
        endcase
      end
      2'd2: begin
        case (mode)
          MODE_POWER: voice_inc = fw << 1;
          default:    voice_inc = fw + (fw >> 1);
        endcase
      end
      2'd3: begin
        case (mode)
          MODE_DOM7:  voice_inc = fw + (fw >> 1) + (fw >> 2);
          MODE_POWER: voice_inc = fw + (fw << 1);
          default:    voice_inc = fw << 1;
        endcase
      end
      default: voice_inc = fw;
    endcase
  endfunction

endpackage

// File: rtl/chord_voicer_if.sv
// Sample-path bus between the note player (master) and the chord voicer (slave).
interface chord_voicer_if #(
  parameter int FREQ_BITS  = 24,
  parameter int NUM_VOICES = 4
);
  logic                  new_sample_ready;
  logic [FREQ_BITS-1:0]  base_note_freq;
  logic                  base_note_active;
  logic [1:0]            chord_mode;
  logic [NUM_VOICES-1:0] voice_en;
  logic signed [15:0]    chords_sample;
  logic                  sample_valid;
  logic                  busy;
  logic                  overrun;

  modport master (
    output new_sample_ready, base_note_freq, base_note_active, chord_mode, voice_en,
    input  chords_sample, sample_valid, busy, overrun
  );

  modport slave (
    input  new_sample_ready, base_note_freq, base_note_active, chord_mode, voice_en,
    output chords_sample, sample_valid, busy, overrun
  );
endinterface

// File: rtl/chord_env_gain.sv
// Linear attack/release gain register; moves one saturating step per accepted tick.
module chord_env_gain #(
  parameter int GAIN_BITS = 8,
  parameter int RAMP_STEP = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 step,
  input  logic                 active,
  output logic [GAIN_BITS-1:0] gain
);
  localparam logic [GAIN_BITS:0] GAIN_MAX = {1'b0, {GAIN_BITS{1'b1}}};
  localparam logic [GAIN_BITS:0] STEP     = (GAIN_BITS + 1)'(RAMP_STEP);

  logic [GAIN_BITS-1:0] gain_q, gain_d;
  logic [GAIN_BITS:0]   up_sum;
  logic [GAIN_BITS:0]   down_diff;

  always_comb begin
    gain_d    = gain_q;
    up_sum    = {1'b0, gain_q} + STEP;
    down_diff = {1'b0, gain_q} - STEP;
    if (step) begin
      if (active) begin
        gain_d = (up_sum > GAIN_MAX) ? GAIN_MAX[GAIN_BITS-1:0] : up_sum[GAIN_BITS-1:0];
      end else begin
        gain_d = ({1'b0, gain_q} < STEP) ? '0 : down_diff[GAIN_BITS-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) gain_q <= '0;
    else       gain_q <= gain_d;
  end

  assign gain = gain_q;
endmodule

// File: rtl/chord_voicer.sv
// Time-multiplexed sawtooth chord mixer: one voice per clock through a shared
// adder, then envelope scaling and saturation to a 16-bit codec sample.
module chord_voicer
  import chord_voicer_pkg::*;
#(
  parameter int FREQ_BITS  = 24,
  parameter int PHASE_BITS = 24,
  parameter int NUM_VOICES = 4,
  parameter int GAIN_BITS  = 8,
  parameter int RAMP_STEP  = 4
) (
  input  logic          clk,
  input  logic          reset,
  chord_voicer_if.slave bus
);
  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int PW = 18 + GAIN_BITS + 1;
  localparam logic [VW-1:0]        LAST_VOICE = VW'(NUM_VOICES - 1);
  localparam logic signed [PW-1:0] SAT_HI     = PW'(32767);
  localparam logic signed [PW-1:0] SAT_LO     = PW'(-32768);

  state_t                state_q, state_d;
  logic [VW-1:0]         voice_q, voice_d;
  logic [PHASE_BITS-1:0] phase_q [NUM_VOICES];
  logic [PHASE_BITS-1:0] phase_d [NUM_VOICES];
  logic [FREQ_BITS-1:0]  freq_q, freq_d;
  logic [1:0]            mode_q, mode_d;
  logic [NUM_VOICES-1:0] en_q, en_d;
  logic signed [17:0]    acc_q, acc_d;
  logic signed [15:0]    sample_q, sample_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;

  logic [GAIN_BITS-1:0]  gain;
  logic                  tick_accept;
  logic                  release_end;
  logic [PHASE_BITS-1:0] cur_phase;
  logic [PHASE_BITS-1:0] next_phase;
  logic signed [15:0]    saw;
  logic signed [17:0]    saw_ext;
  logic signed [PW-1:0]  prod;
  logic signed [PW-1:0]  scaled;
  logic signed [15:0]    sat;

  assign tick_accept = (state_q == ST_IDLE) && bus.new_sample_ready;
  assign release_end = tick_accept && (gain == '0) && !bus.base_note_active;

  chord_env_gain #(
    .GAIN_BITS (GAIN_BITS),
    .RAMP_STEP (RAMP_STEP)
  ) u_gain (
    .clk    (clk),
    .reset  (reset),
    .step   (tick_accept),
    .active (bus.base_note_active),
    .gain   (gain)
  );

  assign cur_phase  = phase_q[voice_q];
  assign next_phase = cur_phase + PHASE_BITS'(voice_inc(32'(freq_q), mode_q, 2'(voice_q)));
  assign saw        = cur_phase[PHASE_BITS-1 -: 16];
  assign saw_ext    = {{2{saw[15]}}, saw};
  assign prod       = PW'(acc_q) * PW'($signed({1'b0, gain}));
  assign scaled     = prod >>> GAIN_BITS;

  always_comb begin
    sat = scaled[15:0];
    if (scaled > SAT_HI)      sat = 16'sh7FFF;
    else if (scaled < SAT_LO) sat = -16'sh8000;
  end

  always_comb begin
    state_d   = state_q;
    voice_d   = voice_q;
    freq_d    = freq_q;
    mode_d    = mode_q;
    en_d      = en_q;
    acc_d     = acc_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    overrun_d = overrun_q;
    for (int i = 0; i < NUM_VOICES; i++) phase_d[i] = phase_q[i];

    if (bus.new_sample_ready && (state_q != ST_IDLE)) overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (bus.new_sample_ready) begin
          state_d = ST_VOICE;
          voice_d = '0;
          busy_d  = 1'b1;
          acc_d   = '0;
          freq_d  = bus.base_note_freq;
          mode_d  = bus.chord_mode;
          en_d    = bus.voice_en;
          // A finished release parks every voice at phase 0 for the next note.
          if (release_end) begin
            en_d = '0;
            for (int i = 0; i < NUM_VOICES; i++) phase_d[i] = '0;
          end
        end
      end
      ST_VOICE: begin
        if (en_q[voice_q]) begin
          acc_d = acc_q + (saw_ext >>> 2);
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (voice_q == VW'(i)) phase_d[i] = next_phase;
          end
        end
        if (voice_q == LAST_VOICE) state_d = ST_SCALE;
        else                       voice_d = voice_q + 1'b1;
      end
      ST_SCALE: begin
        sample_d = sat;
        valid_d  = 1'b1;
        state_d  = ST_OUT;
      end
      ST_OUT: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      voice_q   <= '0;
      freq_q    <= '0;
      mode_q    <= MODE_MAJOR;
      en_q      <= '0;
      acc_q     <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) phase_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      voice_q   <= voice_d;
      freq_q    <= freq_d;
      mode_q    <= mode_d;
      en_q      <= en_d;
      acc_q     <= acc_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      for (int i = 0; i < NUM_VOICES; i++) phase_q[i] <= phase_d[i];
    end
  end

  assign bus.chords_sample = sample_q;
  assign bus.sample_valid  = valid_q;
  assign bus.busy          = busy_q;
  assign bus.overrun       = overrun_q;
endmodule

// File: tb/tb_chord_voicer.sv
// Self-checking bench: a fast-attack instance (RAMP_STEP=255) for mixing checks and
// a slow instance (RAMP_STEP=4) for the envelope ramp, both driven by the same inputs.
module tb_chord_voicer;

  typedef struct {
    logic [1:0]  mode;
    logic [3:0]  en;
    logic [23:0] freq;
    logic        active;
    int          ticks;
    int          exp_sample;
    logic [23:0] ph0;
    logic [23:0] ph1;
    logic [23:0] ph2;
    logic [23:0] ph3;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic [23:0] freq = '0;
  logic        active = 1'b0;
  logic [1:0]  mode = '0;
  logic [3:0]  en = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  chord_voicer_if #(.FREQ_BITS(24), .NUM_VOICES(4)) bus_f ();
  chord_voicer_if #(.FREQ_BITS(24), .NUM_VOICES(4)) bus_s ();

  assign bus_f.new_sample_ready = tick;
  assign bus_f.base_note_freq   = freq;
  assign bus_f.base_note_active = active;
  assign bus_f.chord_mode       = mode;
  assign bus_f.voice_en         = en;
  assign bus_s.new_sample_ready = tick;
  assign bus_s.base_note_freq   = freq;
  assign bus_s.base_note_active = active;
  assign bus_s.chord_mode       = mode;
  assign bus_s.voice_en         = en;

  chord_voicer #(.FREQ_BITS(24), .PHASE_BITS(24), .NUM_VOICES(4), .GAIN_BITS(8), .RAMP_STEP(255))
    u_fast (.clk(clk), .reset(rst), .bus(bus_f));

  chord_voicer #(.FREQ_BITS(24), .PHASE_BITS(24), .NUM_VOICES(4), .GAIN_BITS(8), .RAMP_STEP(4))
    u_slow (.clk(clk), .reset(rst), .bus(bus_s));

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst  = 1'b1;
    tick = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One tick, then wait (bounded) for the sample; returns back in IDLE.
  task automatic runTick(output int lat);
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    lat = 1;
    while (!bus_f.sample_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!bus_f.sample_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL sample_valid_timeout: got 0 expected 1 within 20 cycles");
    end
    @(negedge clk);
  endtask

  task automatic setInputs(input logic [1:0] m, input logic [3:0] e,
                           input logic [23:0] f, input logic a);
    mode = m; en = e; freq = f; active = a;
  endtask

  task automatic applyStimulus(input vec_t v);
    int lat;
    doReset();
    setInputs(v.mode, v.en, v.freq, v.active);
    for (int t = 0; t < v.ticks; t++) runTick(lat);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs [9];
    int   lat;
    int   gain_bad;
    int   valid_cnt;

    vecs[0] = '{2'd0, 4'b0001, 24'h010000, 1'b1, 1,  0,     24'h010000, 24'h0, 24'h0, 24'h0};
    vecs[1] = '{2'd2, 4'b1111, 24'h100000, 1'b1, 16, 2550,  24'h000000, 24'h400000, 24'h800000, 24'hC00000};
    vecs[2] = '{2'd3, 4'b1111, 24'h100000, 1'b1, 2,  7650,  24'h200000, 24'h300000, 24'h400000, 24'h600000};
    vecs[3] = '{2'd1, 4'b0010, 24'h100000, 1'b1, 3,  2422,  24'h0, 24'h390000, 24'h0, 24'h0};
    vecs[4] = '{2'd0, 4'b1000, 24'h200000, 1'b1, 3,  -8160, 24'h0, 24'h0, 24'h0, 24'hC00000};
    vecs[5] = '{2'd2, 4'b0100, 24'h0C0000, 1'b1, 4,  3442,  24'h0, 24'h0, 24'h480000, 24'h0};
    vecs[6] = '{2'd0, 4'b0000, 24'h100000, 1'b1, 2,  0,     24'h0, 24'h0, 24'h0, 24'h0};
    vecs[7] = '{2'd1, 4'b0101, 24'h100000, 1'b1, 2,  2550,  24'h200000, 24'h0, 24'h300000, 24'h0};
    vecs[8] = '{2'd0, 4'b1111, 24'h100000, 1'b0, 3,  0,     24'h0, 24'h0, 24'h0, 24'h0};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_sample",  32'(bus_f.chords_sample), 32'd0);
    checkOutput("reset_valid",   32'(bus_f.sample_valid), 32'd0);
    checkOutput("reset_busy",    32'(bus_f.busy), 32'd0);
    checkOutput("reset_overrun", 32'(bus_f.overrun), 32'd0);
    checkOutput("reset_phase0",  32'(u_fast.phase_q[0]), 32'd0);
    checkOutput("reset_gain",    32'(u_fast.gain), 32'd0);

    // Latency and busy window
    setInputs(2'd0, 4'b0001, 24'h010000, 1'b1);
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    checkOutput("busy_after_tick", 32'(bus_f.busy), 32'd1);
    lat = 1;
    while (!bus_f.sample_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'd6);
    @(negedge clk);
    checkOutput("valid_one_cycle", 32'(bus_f.sample_valid), 32'd0);
    checkOutput("busy_released", 32'(bus_f.busy), 32'd0);

    // Table-driven mixing vectors
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_sample", i), 32'(bus_f.chords_sample), 32'(vecs[i].exp_sample));
      checkOutput($sformatf("vec%0d_phase0", i), 32'(u_fast.phase_q[0]), 32'(vecs[i].ph0));
      checkOutput($sformatf("vec%0d_phase1", i), 32'(u_fast.phase_q[1]), 32'(vecs[i].ph1));
      checkOutput($sformatf("vec%0d_phase2", i), 32'(u_fast.phase_q[2]), 32'(vecs[i].ph2));
      checkOutput($sformatf("vec%0d_phase3", i), 32'(u_fast.phase_q[3]), 32'(vecs[i].ph3));
    end

    // 300 ticks: gain pinned at full scale, saw period of 256 samples
    doReset();
    setInputs(2'd0, 4'b0001, 24'h010000, 1'b1);
    gain_bad = 0;
    for (int t = 1; t <= 300; t++) begin
      runTick(lat);
      if (u_fast.gain != 8'd255) gain_bad++;
      if (t == 129) checkOutput("saw_mid_period", 32'(bus_f.chords_sample), 32'(-8160));
      if (t == 256) checkOutput("saw_wrap_phase", 32'(u_fast.phase_q[0]), 32'd0);
      if (t == 257) checkOutput("saw_period_sample", 32'(bus_f.chords_sample), 32'd0);
    end
    checkOutput("gain_never_wraps", 32'(gain_bad), 32'd0);
    checkOutput("phase0_after_300", 32'(u_fast.phase_q[0]), 32'h002C0000);
    checkOutput("no_overrun_300", 32'(bus_f.overrun), 32'd0);

    // Tick every 3 cycles: only every third tick is accepted
    doReset();
    setInputs(2'd0, 4'b0001, 24'h010000, 1'b1);
    valid_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus_f.sample_valid) valid_cnt++;
      if (c == 3) checkOutput("overrun_before_2nd", 32'(bus_f.overrun), 32'd0);
      if (c == 4) checkOutput("overrun_after_2nd", 32'(bus_f.overrun), 32'd1);
      tick = (c % 3 == 0) && (c < 24);
    end
    checkOutput("accepted_samples", 32'(valid_cnt), 32'd3);
    checkOutput("overrun_sticky", 32'(bus_f.overrun), 32'd1);
    doReset();
    @(negedge clk);
    checkOutput("overrun_cleared_by_reset", 32'(bus_f.overrun), 32'd0);

    // Slow envelope: attack to full scale, release to zero, then phase clear
    setInputs(2'd0, 4'b0001, 24'h010000, 1'b1);
    for (int t = 0; t < 63; t++) runTick(lat);
    checkOutput("attack_63", 32'(u_slow.gain), 32'd252);
    runTick(lat);
    checkOutput("attack_64_sat", 32'(u_slow.gain), 32'd255);
    active = 1'b0;
    for (int t = 0; t < 63; t++) runTick(lat);
    checkOutput("release_63", 32'(u_slow.gain), 32'd3);
    checkOutput("release_phase_running", 32'(u_slow.phase_q[0]), 32'h007F0000);
    runTick(lat);
    checkOutput("release_64_zero", 32'(u_slow.gain), 32'd0);
    checkOutput("release_64_phase", 32'(u_slow.phase_q[0]), 32'h00800000);
    checkOutput("release_64_sample", 32'(bus_s.chords_sample), 32'd0);
    runTick(lat);
    checkOutput("release_end_phase0", 32'(u_slow.phase_q[0]), 32'd0);
    checkOutput("release_end_sample", 32'(bus_s.chords_sample), 32'd0);

    // Reset while voice 2 is being processed
    doReset();
    setInputs(2'd0, 4'b0001, 24'h100000, 1'b1);
    for (int t = 0; t < 3; t++) runTick(lat);
    checkOutput("pre_abort_sample", 32'(bus_f.chords_sample), 32'd2040);
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_sample", 32'(bus_f.chords_sample), 32'd0);
    checkOutput("abort_busy", 32'(bus_f.busy), 32'd0);
    checkOutput("abort_phase0", 32'(u_fast.phase_q[0]), 32'd0);
    valid_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus_f.sample_valid) valid_cnt++;
      @(negedge clk);
    end
    checkOutput("abort_no_valid", 32'(valid_cnt), 32'd0);
    setInputs(2'd0, 4'b0001, 24'h010000, 1'b1);
    runTick(lat);
    checkOutput("post_abort_latency", 32'(lat), 32'd6);
    checkOutput("post_abort_sample", 32'(bus_f.chords_sample), 32'd0);
    checkOutput("post_abort_phase0", 32'(u_fast.phase_q[0]), 32'h00010000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
